c_ram_scheduler: RTL
====================

Name: c_ram_scheduler

Overview:
- Arbitrates one single-port ciphertext RAM among three requesters: a producer (write port), a FIFO consumer (read port 1), and a random-access reader (read port 2).
- The RAM is treated as a ring buffer for the write/read-1 pair. Read port 2 peeks at any address and never moves a pointer.
- Drives the RAM enable, direction, address and write data, and returns read data with a valid strobe.
- Sits between the encryption core, the transmit path and the debug/verify reader.

Parameters:
DATAWIDTH, 8, RAM word width
DATADEPTH, 16, RAM word count; any value >= 2, not necessarily a power of two
ADDRWIDTH, 21, width of op_address and rd2_addr

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of pointers and count
wr_req  in  1  write request
wr_data  in  DATAWIDTH  write word
wr_ack  out  1  one-cycle grant pulse for write
rd1_req  in  1  FIFO pop request
rd1_ack  out  1  one-cycle grant pulse for pop
rd1_data  out  DATAWIDTH  popped word
rd1_valid  out  1  one-cycle strobe, rd1_data valid
rd2_req  in  1  peek request
rd2_addr  in  ADDRWIDTH  peek address
rd2_ack  out  1  one-cycle grant pulse for peek
rd2_err  out  1  one-cycle pulse, peek address out of range
rd2_data  out  DATAWIDTH  peeked word
rd2_valid  out  1  one-cycle strobe, rd2_data valid
ram_en  out  1  RAM enable
ram_w_or_r  out  1  1 = write, 0 = read
op_address  out  ADDRWIDTH  RAM address
ram_din  out  DATAWIDTH  RAM write data
ram_dout  in  DATAWIDTH  RAM read data, valid the cycle after the read access cycle
count  out  clog2(DATADEPTH+1)  words stored
full  out  1  count == DATADEPTH
empty  out  1  count == 0

Behaviour:
Reset values:
- All outputs are 0 except empty = 1.
- wr_ptr = 0, rd_ptr = 0.
- Round-robin last-grant = rd2, so write has first priority after reset.

Eligibility:
- Write is eligible when wr_req && !full.
- Read 1 is eligible when rd1_req && !empty.
- Read 2 is eligible when rd2_req && rd2_addr < DATADEPTH.
- rd2_req with rd2_addr >= DATADEPTH:
  - pulses rd2_err on the next edge;
  - makes no RAM access and gives no ack;
  - does not consume a grant slot;
  - the requester must drop the request.

Arbitration:
- At most one grant per clock edge.
- Round-robin order is W -> R1 -> R2 -> W. The search starts at the requester after the last granted one.
- Ineligible requesters are skipped. With no eligible requester, the grant pointer does not move.

Grant at edge E0 (all registered):
- ram_en = 1 for the cycle E0..E1; ram_en = 0 in any cycle with no grant.
- The granted requester's ack = 1 for E0..E1.
- Write grant:
  - ram_w_or_r = 1, op_address = wr_ptr, ram_din = wr_data;
  - wr_ptr advances; count + 1.
- Read-1 grant:
  - ram_w_or_r = 0, op_address = rd_ptr;
  - rd_ptr advances; count - 1.
- Read-2 grant: ram_w_or_r = 0, op_address = rd2_addr.
- Pointer advance wraps DATADEPTH-1 -> 0. op_address is zero-extended from the pointer.
- count, full and empty are registered and update at the grant edge.

Read data:
- The RAM reads at E1, so ram_dout is valid during E1..E2.
- At E2 the scheduler registers ram_dout into rdN_data and pulses rdN_valid for E2..E3.
- Read latency from grant edge to valid is 2 cycles.
- rdN_data holds its value until the next valid for that port.

Request handshake:
- A requester holds req until it sees ack.
- A req still high on the edge that ends the ack cycle is a new request, so back-to-back accesses are allowed.
- Pipelined reads from both ports may overlap. Each valid is tagged to its port by a 2-stage in-flight shift register.

Flush:
- flush has priority over every grant.
- That cycle: no grant, ram_en = 0, wr_ptr = rd_ptr = count = 0, full = 0, empty = 1.
- Reads already in flight still deliver their valid.

Asynchronous reset mid-operation:
- Clears everything immediately, including in-flight valids.
- No valid or ack appears after reset releases unless a new request arrives.

Test Plan:
- 3 writes (0xA1, 0xA2, 0xA3), then 3 rd1 pops -> rd1_data is 0xA1, 0xA2, 0xA3, each valid 2 cycles after its rd1_ack; count goes 3 -> 0; empty = 1.
- 16 writes with DATADEPTH = 16 -> full = 1, count = 16; a 17th wr_req held 5 cycles gives no wr_ack and ram_en = 0. One pop then lets it in; wr_ptr wraps to 0.
- Empty buffer with rd1_req high -> no rd1_ack. A simultaneous rd2_req to address 4 is granted and rd2_data = RAM[4].
- wr_req, rd1_req and rd2_req held high with a non-empty, non-full buffer -> grant order W, R1, R2, W, R1, R2; ram_en = 1 every cycle; each valid lands on the correct port.
- DATADEPTH = 5: 7 writes interleaved with 7 pops -> pointer sequence 0,1,2,3,4,0,1; data order preserved. rd2_addr = 5 -> rd2_err pulse, no ram_en.
- rst asserted 1 cycle after a rd1 grant -> rd1_valid never asserts; after release count = 0, empty = 1, and the first grant goes to write.

Source files
------------

// File: rtl/c_ram_scheduler_if.sv
// rtl/c_ram_scheduler_if.sv - requester, RAM and status signals of the ciphertext RAM scheduler
interface c_ram_scheduler_if #(
    parameter int DATAWIDTH = 8,
    parameter int DATADEPTH = 16,
    parameter int ADDRWIDTH = 21
);
    localparam int CNTW = $clog2(DATADEPTH + 1);

    logic                 flush;
    logic                 wr_req;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 wr_ack;
    logic                 rd1_req;
    logic                 rd1_ack;
    logic [DATAWIDTH-1:0] rd1_data;
    logic                 rd1_valid;
    logic                 rd2_req;
    logic [ADDRWIDTH-1:0] rd2_addr;
    logic                 rd2_ack;
    logic                 rd2_err;
    logic [DATAWIDTH-1:0] rd2_data;
    logic                 rd2_valid;
    logic                 ram_en;
    logic                 ram_w_or_r;
    logic [ADDRWIDTH-1:0] op_address;
    logic [DATAWIDTH-1:0] ram_din;
    logic [DATAWIDTH-1:0] ram_dout;
    logic [CNTW-1:0]      count;
    logic                 full;
    logic                 empty;

    modport slave (
        input  flush, wr_req, wr_data, rd1_req, rd2_req, rd2_addr, ram_dout,
        output wr_ack, rd1_ack, rd1_data, rd1_valid, rd2_ack, rd2_err, rd2_data, rd2_valid,
        output ram_en, ram_w_or_r, op_address, ram_din, count, full, empty
    );

    modport master (
        output flush, wr_req, wr_data, rd1_req, rd2_req, rd2_addr, ram_dout,
        input  wr_ack, rd1_ack, rd1_data, rd1_valid, rd2_ack, rd2_err, rd2_data, rd2_valid,
        input  ram_en, ram_w_or_r, op_address, ram_din, count, full, empty
    );
endinterface

// File: rtl/c_ram_scheduler.sv
// rtl/c_ram_scheduler.sv - single-port ciphertext RAM scheduler: ring-buffer writer, FIFO reader, random-access peek
module c_ram_scheduler #(
    parameter int DATAWIDTH = 8,
    parameter int DATADEPTH = 16,
    parameter int ADDRWIDTH = 21
) (
    input  logic            clk,
    input  logic            rst,
    c_ram_scheduler_if.slave bus
);
    localparam int CNTW = $clog2(DATADEPTH + 1);
    localparam int PTRW = $clog2(DATADEPTH);
    localparam logic [PTRW-1:0]    LAST_PTR    = PTRW'(DATADEPTH - 1);
    localparam logic [CNTW-1:0]    FULL_CNT    = CNTW'(DATADEPTH);
    localparam logic [ADDRWIDTH:0] DEPTH_LIMIT = (ADDRWIDTH + 1)'(DATADEPTH);

    localparam logic [1:0] SEL_W    = 2'd0;
    localparam logic [1:0] SEL_R1   = 2'd1;
    localparam logic [1:0] SEL_R2   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ADDRWIDTH-1:0] ptr_addr(input logic [PTRW-1:0] p);
        logic [ADDRWIDTH-1:0] a;
        a = '0;
        a[PTRW-1:0] = p;
        return a;
    endfunction

    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [1:0]      last_grant;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_inc;
    logic [CNTW-1:0] cnt_dec;
    logic            full_q;
    logic            empty_q;
    // in-flight read tags, bit 0 = port 1, bit 1 = port 2
    logic [1:0]      inflight0;
    logic [1:0]      inflight1;

    logic            rd2_in_range;
    logic            elig_w;
    logic            elig_r1;
    logic            elig_r2;
    logic [1:0]      sel;

    assign cnt_inc      = cnt + 1'b1;
    assign cnt_dec      = cnt - 1'b1;
    assign rd2_in_range = ({1'b0, bus.rd2_addr} < DEPTH_LIMIT);
    assign elig_w       = bus.wr_req && !full_q;
    assign elig_r1      = bus.rd1_req && !empty_q;
    assign elig_r2      = bus.rd2_req && rd2_in_range;

    assign bus.count = cnt;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;

    // round robin W -> R1 -> R2 -> W, search begins after the last winner
    always_comb begin
        sel = SEL_NONE;
        case (last_grant)
            SEL_W: begin
                if (elig_r1)      sel = SEL_R1;
                else if (elig_r2) sel = SEL_R2;
                else if (elig_w)  sel = SEL_W;
            end
            SEL_R1: begin
                if (elig_r2)      sel = SEL_R2;
                else if (elig_w)  sel = SEL_W;
                else if (elig_r1) sel = SEL_R1;
            end
            default: begin
                if (elig_w)       sel = SEL_W;
                else if (elig_r1) sel = SEL_R1;
                else if (elig_r2) sel = SEL_R2;
            end
        endcase
        if (bus.flush) sel = SEL_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            last_grant     <= SEL_R2;
            cnt            <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            inflight0      <= 2'b00;
            inflight1      <= 2'b00;
            bus.wr_ack     <= 1'b0;
            bus.rd1_ack    <= 1'b0;
            bus.rd2_ack    <= 1'b0;
            bus.rd2_err    <= 1'b0;
            bus.rd1_data   <= '0;
            bus.rd1_valid  <= 1'b0;
            bus.rd2_data   <= '0;
            bus.rd2_valid  <= 1'b0;
            bus.ram_en     <= 1'b0;
            bus.ram_w_or_r <= 1'b0;
            bus.op_address <= '0;
            bus.ram_din    <= '0;
        end else begin
            bus.wr_ack     <= 1'b0;
            bus.rd1_ack    <= 1'b0;
            bus.rd2_ack    <= 1'b0;
            bus.ram_en     <= 1'b0;
            bus.ram_w_or_r <= 1'b0;
            bus.rd2_err    <= bus.rd2_req && !rd2_in_range;

            // RAM data arrives one cycle after the access cycle; tag follows it
            inflight0     <= {sel == SEL_R2, sel == SEL_R1};
            inflight1     <= inflight0;
            bus.rd1_valid <= inflight1[0];
            bus.rd2_valid <= inflight1[1];
            if (inflight1[0]) bus.rd1_data <= bus.ram_dout;
            if (inflight1[1]) bus.rd2_data <= bus.ram_dout;

            if (bus.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
            end else begin
                case (sel)
                    SEL_W: begin
                        bus.ram_en     <= 1'b1;
                        bus.ram_w_or_r <= 1'b1;
                        bus.op_address <= ptr_addr(wr_ptr);
                        bus.ram_din    <= bus.wr_data;
                        bus.wr_ack     <= 1'b1;
                        wr_ptr         <= ptr_next(wr_ptr);
                        cnt            <= cnt_inc;
                        full_q         <= (cnt_inc == FULL_CNT);
                        empty_q        <= 1'b0;
                        last_grant     <= SEL_W;
                    end
                    SEL_R1: begin
                        bus.ram_en     <= 1'b1;
                        bus.op_address <= ptr_addr(rd_ptr);
                        bus.rd1_ack    <= 1'b1;
                        rd_ptr         <= ptr_next(rd_ptr);
                        cnt            <= cnt_dec;
                        full_q         <= 1'b0;
                        empty_q        <= (cnt_dec == '0);
                        last_grant     <= SEL_R1;
                    end
                    SEL_R2: begin
                        bus.ram_en     <= 1'b1;
                        bus.op_address <= bus.rd2_addr;
                        bus.rd2_ack    <= 1'b1;
                        last_grant     <= SEL_R2;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule
